// File: rtl/register_file_if.sv
// Bus bundle for register_file: main, lhs, rhs and xfer access paths plus bank control.
// Widths are derived from the same WIDTH/COUNT/BANKS triple the register file uses.
interface register_file_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int BANKS = 2
);
  localparam int SELW  = $clog2(COUNT);
  localparam int PSELW = (COUNT > 2) ? $clog2(COUNT / 2) : 1;
  localparam int BSELW = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic [WIDTH-1:0]   main_in;
  logic               load_main;
  logic [SELW-1:0]    load_sel;
  logic               assert_main;
  logic [SELW-1:0]    main_sel;
  logic [WIDTH-1:0]   main_out;
  logic               main_en;
  logic               assert_lhs;
  logic [SELW-1:0]    lhs_sel;
  logic [WIDTH-1:0]   lhs_out;
  logic               lhs_en;
  logic               assert_rhs;
  logic [SELW-1:0]    rhs_sel;
  logic [WIDTH-1:0]   rhs_out;
  logic               rhs_en;
  logic [2*WIDTH-1:0] xfer_in;
  logic               load_xfer;
  logic               assert_xfer;
  logic [PSELW-1:0]   pair_sel;
  logic [2*WIDTH-1:0] xfer_out;
  logic               xfer_en;
  logic               bank_next;
  logic [BSELW-1:0]   bank;
  logic               sel_err;

  modport master (
    output main_in, load_main, load_sel, assert_main, main_sel,
    output assert_lhs, lhs_sel, assert_rhs, rhs_sel,
    output xfer_in, load_xfer, assert_xfer, pair_sel, bank_next,
    input  main_out, main_en, lhs_out, lhs_en, rhs_out, rhs_en,
    input  xfer_out, xfer_en, bank, sel_err
  );

  modport slave (
    input  main_in, load_main, load_sel, assert_main, main_sel,
    input  assert_lhs, lhs_sel, assert_rhs, rhs_sel,
    input  xfer_in, load_xfer, assert_xfer, pair_sel, bank_next,
    output main_out, main_en, lhs_out, lhs_en, rhs_out, rhs_en,
    output xfer_out, xfer_en, bank, sel_err
  );
endinterface

// File: rtl/register_file.sv
// Banked general-purpose register file: COUNT x WIDTH registers per bank, combinational
// reads from the active bank on four ports, clocked writes with main-over-xfer priority.
module register_file #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int BANKS = 2
) (
  input  logic clk,
  input  logic reset,
  register_file_if.slave bus
);
  localparam int SELW  = $clog2(COUNT);
  localparam int PSELW = (COUNT > 2) ? $clog2(COUNT / 2) : 1;
  localparam int BSELW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int PAIRS = COUNT / 2;

  logic [WIDTH-1:0]   regs_q [BANKS][COUNT];
  logic [WIDTH-1:0]   regs_d [BANKS][COUNT];
  logic [BSELW-1:0]   bank_q;
  logic [BSELW-1:0]   bank_d;
  logic [WIDTH-1:0]   main_rd_s;
  logic [WIDTH-1:0]   lhs_rd_s;
  logic [WIDTH-1:0]   rhs_rd_s;
  logic [2*WIDTH-1:0] xfer_rd_s;
  logic               main_oor_s;
  logic               load_oor_s;
  logic               lhs_oor_s;
  logic               rhs_oor_s;
  logic               pair_oor_s;

  function automatic logic sel_oor(input logic [SELW-1:0] sel);
    return 32'(sel) >= COUNT;
  endfunction

  function automatic logic pair_oor(input logic [PSELW-1:0] pair);
    return 32'(pair) >= PAIRS;
  endfunction

  // Range flags; only matter when COUNT is not a power of two
  always_comb begin
    main_oor_s = sel_oor(bus.main_sel);
    load_oor_s = sel_oor(bus.load_sel);
    lhs_oor_s  = sel_oor(bus.lhs_sel);
    rhs_oor_s  = sel_oor(bus.rhs_sel);
    pair_oor_s = pair_oor(bus.pair_sel);
  end

  // Read muxes as AND-OR over the active bank; an out-of-range select matches nothing and reads 0
  always_comb begin
    main_rd_s = {WIDTH{1'b0}};
    lhs_rd_s  = {WIDTH{1'b0}};
    rhs_rd_s  = {WIDTH{1'b0}};
    xfer_rd_s = {(2*WIDTH){1'b0}};
    for (int b = 0; b < BANKS; b++) begin
      for (int r = 0; r < COUNT; r++) begin
        main_rd_s = main_rd_s | (regs_q[b][r] &
                    {WIDTH{(32'(bank_q) == b) && (32'(bus.main_sel) == r)}});
        lhs_rd_s  = lhs_rd_s  | (regs_q[b][r] &
                    {WIDTH{(32'(bank_q) == b) && (32'(bus.lhs_sel) == r)}});
        rhs_rd_s  = rhs_rd_s  | (regs_q[b][r] &
                    {WIDTH{(32'(bank_q) == b) && (32'(bus.rhs_sel) == r)}});
      end
      for (int p = 0; p < PAIRS; p++) begin
        xfer_rd_s = xfer_rd_s | ({regs_q[b][2*p+1], regs_q[b][2*p]} &
                    {(2*WIDTH){(32'(bank_q) == b) && (32'(bus.pair_sel) == p)}});
      end
    end
  end

  // Next register state: main write beats the xfer half it collides with
  always_comb begin
    regs_d = regs_q;
    for (int b = 0; b < BANKS; b++) begin
      for (int r = 0; r < COUNT; r++) begin
        if (bus.load_main && (32'(bank_q) == b) && (32'(bus.load_sel) == r)) begin
          regs_d[b][r] = bus.main_in;
        end else if (bus.load_xfer && (32'(bank_q) == b) && (32'(bus.pair_sel) == r / 2)) begin
          regs_d[b][r] = (r % 2 == 1) ? bus.xfer_in[2*WIDTH-1:WIDTH] : bus.xfer_in[WIDTH-1:0];
        end else begin
          regs_d[b][r] = regs_q[b][r];
        end
      end
    end
  end

  // Next bank index, wrapping at BANKS-1
  always_comb begin
    if (bus.bank_next) begin
      if (32'(bank_q) == BANKS - 1) begin
        bank_d = {BSELW{1'b0}};
      end else begin
        bank_d = bank_q + BSELW'(1);
      end
    end else begin
      bank_d = bank_q;
    end
  end

  // Register and bank state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int r = 0; r < COUNT; r++) begin
          regs_q[b][r] <= {WIDTH{1'b0}};
        end
      end
      bank_q <= {BSELW{1'b0}};
    end else begin
      regs_q <= regs_d;
      bank_q <= bank_d;
    end
  end

  // Enables gate the read data and are forced low while reset is held
  assign bus.main_en  = reset & bus.assert_main;
  assign bus.lhs_en   = reset & bus.assert_lhs;
  assign bus.rhs_en   = reset & bus.assert_rhs;
  assign bus.xfer_en  = reset & bus.assert_xfer;
  assign bus.main_out = {WIDTH{bus.main_en}} & main_rd_s;
  assign bus.lhs_out  = {WIDTH{bus.lhs_en}} & lhs_rd_s;
  assign bus.rhs_out  = {WIDTH{bus.rhs_en}} & rhs_rd_s;
  assign bus.xfer_out = {(2*WIDTH){bus.xfer_en}} & xfer_rd_s;
  assign bus.bank     = bank_q;
  assign bus.sel_err  = reset & (((bus.assert_main | bus.load_main) & main_oor_s & ~bus.load_main) |
                                 (bus.assert_main & main_oor_s) |
                                 (bus.load_main & load_oor_s) |
                                 (bus.assert_lhs & lhs_oor_s) |
                                 (bus.assert_rhs & rhs_oor_s) |
                                 ((bus.assert_xfer | bus.load_xfer) & pair_oor_s));
endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file (WIDTH=8, COUNT=6, BANKS=2)
// against an array-based reference model.
module tb_register_file;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [7:0] model [2][6];
  int         bank_m = 0;

  register_file_if #(.WIDTH(8), .COUNT(6), .BANKS(2)) bus_if ();
  register_file #(.WIDTH(8), .COUNT(6), .BANKS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    bus_if.main_in = 8'h00;      bus_if.load_main = 1'b0;  bus_if.load_sel = 3'd0;
    bus_if.assert_main = 1'b0;   bus_if.main_sel = 3'd0;
    bus_if.assert_lhs = 1'b0;    bus_if.lhs_sel = 3'd0;
    bus_if.assert_rhs = 1'b0;    bus_if.rhs_sel = 3'd0;
    bus_if.xfer_in = 16'h0000;   bus_if.load_xfer = 1'b0;
    bus_if.assert_xfer = 1'b0;   bus_if.pair_sel = 2'd0;
    bus_if.bank_next = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  function automatic logic [7:0] rd(input int s);
    return (s < 6) ? model[bank_m][s] : 8'h00;
  endfunction

  // Reference model: pair write first, main write overrides, then bank advance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 6; r++) model[b][r] = 8'h00;
      bank_m = 0;
    end else begin
      if (bus_if.load_xfer && int'(bus_if.pair_sel) < 3) begin
        model[bank_m][2*int'(bus_if.pair_sel)]   = bus_if.xfer_in[7:0];
        model[bank_m][2*int'(bus_if.pair_sel)+1] = bus_if.xfer_in[15:8];
      end
      if (bus_if.load_main && int'(bus_if.load_sel) < 6)
        model[bank_m][int'(bus_if.load_sel)] = bus_if.main_in;
      if (bus_if.bank_next) bank_m = (bank_m + 1) % 2;
    end
  end

  // Every falling edge: all outputs against the model
  always @(negedge clk) begin
    logic [7:0]  e_main, e_lhs, e_rhs;
    logic [15:0] e_xfer;
    logic        e_err;
    int          p;
    p      = int'(bus_if.pair_sel);
    e_main = (reset && bus_if.assert_main) ? rd(int'(bus_if.main_sel)) : 8'h00;
    e_lhs  = (reset && bus_if.assert_lhs)  ? rd(int'(bus_if.lhs_sel))  : 8'h00;
    e_rhs  = (reset && bus_if.assert_rhs)  ? rd(int'(bus_if.rhs_sel))  : 8'h00;
    e_xfer = (reset && bus_if.assert_xfer && p < 3) ? {rd(2*p+1), rd(2*p)} : 16'h0000;
    e_err  = reset && (((bus_if.assert_main && int'(bus_if.main_sel) >= 6)) ||
                       (bus_if.load_main && int'(bus_if.load_sel) >= 6) ||
                       (bus_if.assert_lhs && int'(bus_if.lhs_sel) >= 6) ||
                       (bus_if.assert_rhs && int'(bus_if.rhs_sel) >= 6) ||
                       ((bus_if.assert_xfer || bus_if.load_xfer) && p >= 3));
    chk("main_out", bus_if.main_out, e_main);
    chk("lhs_out",  bus_if.lhs_out,  e_lhs);
    chk("rhs_out",  bus_if.rhs_out,  e_rhs);
    chk("xfer_out", bus_if.xfer_out, e_xfer);
    chk("main_en",  bus_if.main_en,  reset & bus_if.assert_main);
    chk("lhs_en",   bus_if.lhs_en,   reset & bus_if.assert_lhs);
    chk("rhs_en",   bus_if.rhs_en,   reset & bus_if.assert_rhs);
    chk("xfer_en",  bus_if.xfer_en,  reset & bus_if.assert_xfer);
    chk("bank",     bus_if.bank,     reset ? bank_m : 0);
    chk("sel_err",  bus_if.sel_err,  e_err);
  end

  initial begin
    idle();
    bus_if.assert_main = 1'b1;
    @(negedge clk); #1;
    chk("rst_main_en", bus_if.main_en, 1'b0);
    chk("rst_bank", bus_if.bank, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Main write; old value visible during the write cycle
    idle();
    bus_if.load_main = 1'b1; bus_if.load_sel = 3'd2; bus_if.main_in = 8'hA5;
    bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd2;
    @(negedge clk); #1;
    chk("wr_cycle_old", bus_if.main_out, 8'h00);
    next(); bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd2;
    @(negedge clk); #1;
    chk("wr_visible", bus_if.main_out, 8'hA5);
    chk("wr_main_en", bus_if.main_en, 1'b1);

    // Pair write then split reads
    next(); bus_if.load_xfer = 1'b1; bus_if.pair_sel = 2'd1; bus_if.xfer_in = 16'hBEEF;
    next();
    bus_if.assert_lhs = 1'b1; bus_if.lhs_sel = 3'd2;
    bus_if.assert_rhs = 1'b1; bus_if.rhs_sel = 3'd3;
    bus_if.assert_xfer = 1'b1; bus_if.pair_sel = 2'd1;
    @(negedge clk); #1;
    chk("pair_lo", bus_if.lhs_out, 8'hEF);
    chk("pair_hi", bus_if.rhs_out, 8'hBE);
    chk("pair_xfer", bus_if.xfer_out, 16'hBEEF);

    // Write conflict: main wins its register, the other half keeps xfer data
    next();
    bus_if.load_xfer = 1'b1; bus_if.pair_sel = 2'd0; bus_if.xfer_in = 16'h1234;
    bus_if.load_main = 1'b1; bus_if.load_sel = 3'd1; bus_if.main_in = 8'h99;
    next(); bus_if.assert_xfer = 1'b1; bus_if.pair_sel = 2'd0;
    @(negedge clk); #1;
    chk("conflict", bus_if.xfer_out, 16'h9934);

    // Bank switching; same-cycle write lands in the old bank
    next(); bus_if.load_main = 1'b1; bus_if.load_sel = 3'd0; bus_if.main_in = 8'h11;
    next(); bus_if.bank_next = 1'b1;
    bus_if.load_main = 1'b1; bus_if.load_sel = 3'd0; bus_if.main_in = 8'h22;
    next(); bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd0;
    @(negedge clk); #1;
    chk("bank1_idx", bus_if.bank, 1'b1);
    chk("bank1_r0", bus_if.main_out, 8'h00);
    next(); bus_if.bank_next = 1'b1; bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd0;
    next(); bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd0;
    @(negedge clk); #1;
    chk("bank0_idx", bus_if.bank, 1'b0);
    chk("bank0_r0", bus_if.main_out, 8'h22);

    // Range check on COUNT=6
    next();
    bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd7;
    bus_if.load_main = 1'b1; bus_if.load_sel = 3'd6; bus_if.main_in = 8'hFF;
    @(negedge clk); #1;
    chk("oor_out", bus_if.main_out, 8'h00);
    chk("oor_en", bus_if.main_en, 1'b1);
    chk("oor_err", bus_if.sel_err, 1'b1);
    next(); bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd2;
    @(negedge clk); #1;
    chk("oor_nowrite", bus_if.main_out, 8'hEF);
    chk("ok_noerr", bus_if.sel_err, 1'b0);

    // Asynchronous reset between edges with bank=1 and data present
    next(); bus_if.bank_next = 1'b1;
    next(); bus_if.load_main = 1'b1; bus_if.load_sel = 3'd0; bus_if.main_in = 8'h77;
    next(); bus_if.assert_main = 1'b1; bus_if.main_sel = 3'd0;
    @(negedge clk); #1;
    chk("pre_rst_bank", bus_if.bank, 1'b1);
    chk("pre_rst_data", bus_if.main_out, 8'h77);
    #2 reset = 1'b0;
    #1;
    chk("async_data", bus_if.main_out, 8'h00);
    chk("async_en", bus_if.main_en, 1'b0);
    chk("async_bank", bus_if.bank, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      next();
      bus_if.main_in     = 8'($urandom);
      bus_if.load_main   = 1'($urandom);
      bus_if.load_sel    = 3'($urandom_range(0, 7));
      bus_if.assert_main = 1'($urandom);
      bus_if.main_sel    = 3'($urandom_range(0, 7));
      bus_if.assert_lhs  = 1'($urandom);
      bus_if.lhs_sel     = 3'($urandom_range(0, 7));
      bus_if.assert_rhs  = 1'($urandom);
      bus_if.rhs_sel     = 3'($urandom_range(0, 7));
      bus_if.xfer_in     = 16'($urandom);
      bus_if.load_xfer   = 1'($urandom);
      bus_if.assert_xfer = 1'($urandom);
      bus_if.pair_sel    = 2'($urandom_range(0, 3));
      bus_if.bank_next   = ($urandom_range(0, 7) == 0);
    end
    next();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
